// File: rtl/fir_xifu_pkg.sv
// Shared types for the FIR X-interface coprocessor unit: opcode encoding,
// writeback entry flags and per-entry retirement state.
package fir_xifu_pkg;

   typedef enum logic [1:0] {
      XFIR_OTHER = 2'd0,
      XFIRLW     = 2'd1,
      XFIRSW     = 2'd2,
      XFIRDOTP   = 2'd3
   } fir_xifu_instr_t;

   typedef enum logic [1:0] {
      WB_PEND,
      WB_WAITMEM,
      WB_READY,
      WB_DEAD
   } fir_xifu_wb_state_e;

   // Control half of a writeback entry; width-parametrised payload lives in
   // parallel arrays inside the buffer so ID/DATA widths stay free.
   typedef struct packed {
      logic            valid;
      fir_xifu_instr_t instr;
      logic            committed;
      logic            killed;
      logic            mem_done;
   } fir_xifu_wb_entry_t;

   function automatic logic is_mem_instr(fir_xifu_instr_t instr);
      return (instr == XFIRLW) || (instr == XFIRSW);
   endfunction

   function automatic fir_xifu_wb_state_e wb_state(fir_xifu_wb_entry_t e);
      if (!e.valid || (!e.killed && !e.committed)) return WB_PEND;
      if (e.killed) return WB_DEAD;
      if (is_mem_instr(e.instr) && !e.mem_done) return WB_WAITMEM;
      return WB_READY;
   endfunction

endpackage

// File: rtl/fir_xifu_id_cam.sv
// DEPTH-way instruction-ID match; one-hot hit vector over the valid entries.
module fir_xifu_id_cam #(
   parameter int DEPTH = 4,
   parameter int ID_W  = 4
) (
   input  logic                       en_i,
   input  logic [ID_W-1:0]            key_i,
   input  logic [DEPTH-1:0]           valid_i,
   input  logic [DEPTH-1:0][ID_W-1:0] ids_i,
   output logic [DEPTH-1:0]           hit_o
);

   for (genvar i = 0; i < DEPTH; i++) begin : g_way
      assign hit_o[i] = en_i & valid_i[i] & (ids_i[i] == key_i);
   end

endmodule

// File: rtl/fir_xifu_wb_buf.sv
// Multi-outstanding in-order writeback buffer for the FIR XIF unit: collects
// commit/kill and memory results per ID, retires via XIF result + FIR RF write.
module fir_xifu_wb_buf
   import fir_xifu_pkg::*;
#(
   parameter int DEPTH     = 4,
   parameter int ID_W      = 4,
   parameter int DATA_W    = 32,
   parameter int RF_ADDR_W = 2
) (
   input  logic                       clk_i,
   input  logic                       rst_ni,
   input  logic                       ex_valid_i,
   output logic                       ex_ready_o,
   input  logic [ID_W-1:0]            ex_id_i,
   input  fir_xifu_instr_t            ex_instr_i,
   input  logic [RF_ADDR_W-1:0]       ex_rd_i,
   input  logic [4:0]                 ex_rs1_i,
   input  logic [DATA_W-1:0]          ex_result_i,
   input  logic                       commit_valid_i,
   input  logic [ID_W-1:0]            commit_id_i,
   input  logic                       commit_kill_i,
   input  logic                       mem_result_valid_i,
   input  logic [ID_W-1:0]            mem_result_id_i,
   input  logic [DATA_W-1:0]          mem_rdata_i,
   output logic                       result_valid_o,
   input  logic                       result_ready_i,
   output logic [ID_W-1:0]            result_id_o,
   output logic [DATA_W-1:0]          result_data_o,
   output logic [4:0]                 result_rd_o,
   output logic                       result_we_o,
   output logic                       rf_write_o,
   output logic [RF_ADDR_W-1:0]       rf_addr_o,
   output logic [DATA_W-1:0]          rf_wdata_o,
   output logic                       kill_o,
   output logic [ID_W-1:0]            kill_id_o,
   output logic [$clog2(DEPTH):0]     occupancy_o
);

   localparam int IW = $clog2(DEPTH);
   localparam int PW = IW + 1;

   fir_xifu_wb_entry_t [DEPTH-1:0]        ent_q, ent_d;
   logic [DEPTH-1:0][ID_W-1:0]            id_q;
   logic [DEPTH-1:0][RF_ADDR_W-1:0]       rd_q;
   logic [DEPTH-1:0][4:0]                 rs1_q;
   logic [DEPTH-1:0][DATA_W-1:0]          result_q;
   logic [DEPTH-1:0][DATA_W-1:0]          rdata_q;
   logic [PW-1:0]                         head_q, head_d, tail_q, tail_d;
   logic                                  kill_q;
   logic [ID_W-1:0]                       kill_id_q;

   logic [IW-1:0]              head_idx, tail_idx;
   logic                       full, push, pop;
   fir_xifu_wb_entry_t         head_ent;
   fir_xifu_wb_state_e         head_st;
   logic                       head_mem, head_rf;
   logic [DEPTH-1:0]           cam_valid, cmt_hit, mem_hit;
   logic [DEPTH-1:0][ID_W-1:0] cam_ids;

   assign head_idx    = head_q[IW-1:0];
   assign tail_idx    = tail_q[IW-1:0];
   assign occupancy_o = tail_q - head_q;
   assign full        = (occupancy_o == PW'(DEPTH));
   assign ex_ready_o  = !full;
   assign push        = ex_valid_i & ex_ready_o;

   assign head_ent = ent_q[head_idx];
   assign head_st  = wb_state(head_ent);
   assign head_mem = is_mem_instr(head_ent.instr);
   assign head_rf  = (head_ent.instr == XFIRLW) || (head_ent.instr == XFIRDOTP);

   assign result_valid_o = (head_st == WB_READY);
   assign pop = (head_st == WB_DEAD) | (result_valid_o & result_ready_i);

   // The entry being pushed is visible to both lookups so early events land.
   for (genvar i = 0; i < DEPTH; i++) begin : g_view
      assign cam_valid[i] = ent_q[i].valid | (push & (tail_idx == IW'(i)));
      assign cam_ids[i]   = (push & (tail_idx == IW'(i))) ? ex_id_i : id_q[i];
   end

   fir_xifu_id_cam #(.DEPTH(DEPTH), .ID_W(ID_W)) u_cmt_cam (
      .en_i    (commit_valid_i),
      .key_i   (commit_id_i),
      .valid_i (cam_valid),
      .ids_i   (cam_ids),
      .hit_o   (cmt_hit)
   );

   fir_xifu_id_cam #(.DEPTH(DEPTH), .ID_W(ID_W)) u_mem_cam (
      .en_i    (mem_result_valid_i),
      .key_i   (mem_result_id_i),
      .valid_i (cam_valid),
      .ids_i   (cam_ids),
      .hit_o   (mem_hit)
   );

   always_comb begin
      ent_d = ent_q;
      for (int i = 0; i < DEPTH; i++) begin
         if (pop && (head_idx == IW'(i))) ent_d[i].valid = 1'b0;
         if (push && (tail_idx == IW'(i)))
            ent_d[i] = '{valid: 1'b1, instr: ex_instr_i, committed: 1'b0,
                         killed: 1'b0, mem_done: 1'b0};
         if (cmt_hit[i]) begin
            if (commit_kill_i) ent_d[i].killed    = 1'b1;
            else               ent_d[i].committed = 1'b1;
         end
         if (mem_hit[i] && !ent_d[i].killed) ent_d[i].mem_done = 1'b1;
      end
   end

   assign head_d = head_q + PW'(pop);
   assign tail_d = tail_q + PW'(push);

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         ent_q     <= '0;
         head_q    <= '0;
         tail_q    <= '0;
         kill_q    <= 1'b0;
         kill_id_q <= '0;
      end else begin
         ent_q     <= ent_d;
         head_q    <= head_d;
         tail_q    <= tail_d;
         kill_q    <= commit_valid_i & commit_kill_i & (|cmt_hit);
         kill_id_q <= commit_id_i;
      end
   end

   // Payload needs no reset: every read is qualified by a valid entry.
   always_ff @(posedge clk_i) begin
      if (push) begin
         id_q[tail_idx]     <= ex_id_i;
         rd_q[tail_idx]     <= ex_rd_i;
         rs1_q[tail_idx]    <= ex_rs1_i;
         result_q[tail_idx] <= ex_result_i;
      end
      for (int i = 0; i < DEPTH; i++)
         if (mem_hit[i] && !ent_d[i].killed) rdata_q[i] <= mem_rdata_i;
   end

   assign result_id_o   = result_valid_o ? id_q[head_idx] : '0;
   assign result_data_o = result_valid_o ? result_q[head_idx] : '0;
   assign result_we_o   = result_valid_o & head_mem;
   assign result_rd_o   = result_we_o ? rs1_q[head_idx] : 5'd0;

   assign rf_write_o = result_valid_o & result_ready_i & head_rf;
   assign rf_addr_o  = rf_write_o ? rd_q[head_idx] : '0;
   assign rf_wdata_o = !rf_write_o ? '0 :
                       (head_ent.instr == XFIRLW) ? rdata_q[head_idx] : result_q[head_idx];

   assign kill_o    = kill_q;
   assign kill_id_o = kill_q ? kill_id_q : '0;

   a_uniq_id: assert property (@(posedge clk_i) disable iff (!rst_ni)
      $onehot0(cmt_hit) && $onehot0(mem_hit));

endmodule

// File: tb/tb_fir_xifu_wb_buf.sv
// Directed bench for fir_xifu_wb_buf: queue-level reference model compared
// every cycle, plus hand-computed literal checks per scenario.
module tb_fir_xifu_wb_buf;
   import fir_xifu_pkg::*;

   localparam int DEPTH = 4;

   logic            clk = 1'b0;
   logic            rst_ni;
   logic            ex_valid_i, ex_ready_o;
   logic [3:0]      ex_id_i;
   fir_xifu_instr_t ex_instr_i;
   logic [1:0]      ex_rd_i;
   logic [4:0]      ex_rs1_i;
   logic [31:0]     ex_result_i;
   logic            commit_valid_i, commit_kill_i;
   logic [3:0]      commit_id_i;
   logic            mem_result_valid_i;
   logic [3:0]      mem_result_id_i;
   logic [31:0]     mem_rdata_i;
   logic            result_valid_o, result_ready_i, result_we_o;
   logic [3:0]      result_id_o;
   logic [31:0]     result_data_o;
   logic [4:0]      result_rd_o;
   logic            rf_write_o;
   logic [1:0]      rf_addr_o;
   logic [31:0]     rf_wdata_o;
   logic            kill_o;
   logic [3:0]      kill_id_o;
   logic [2:0]      occupancy_o;

   fir_xifu_wb_buf #(.DEPTH(DEPTH), .ID_W(4), .DATA_W(32), .RF_ADDR_W(2)) dut (
      .clk_i(clk), .rst_ni(rst_ni),
      .ex_valid_i(ex_valid_i), .ex_ready_o(ex_ready_o), .ex_id_i(ex_id_i),
      .ex_instr_i(ex_instr_i), .ex_rd_i(ex_rd_i), .ex_rs1_i(ex_rs1_i),
      .ex_result_i(ex_result_i),
      .commit_valid_i(commit_valid_i), .commit_id_i(commit_id_i),
      .commit_kill_i(commit_kill_i),
      .mem_result_valid_i(mem_result_valid_i), .mem_result_id_i(mem_result_id_i),
      .mem_rdata_i(mem_rdata_i),
      .result_valid_o(result_valid_o), .result_ready_i(result_ready_i),
      .result_id_o(result_id_o), .result_data_o(result_data_o),
      .result_rd_o(result_rd_o), .result_we_o(result_we_o),
      .rf_write_o(rf_write_o), .rf_addr_o(rf_addr_o), .rf_wdata_o(rf_wdata_o),
      .kill_o(kill_o), .kill_id_o(kill_id_o), .occupancy_o(occupancy_o)
   );

   always #10 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   typedef struct {
      logic [3:0]      id;
      fir_xifu_instr_t instr;
      logic [1:0]      rd;
      logic [4:0]      rs1;
      logic [31:0]     res;
      logic [31:0]     rdata;
      bit              cm, kl, md;
   } rec_t;

   rec_t       q[$];
   bit         kill_pend = 0;
   logic [3:0] kill_pend_id = '0;
   bit         chk_en = 0;

   function automatic bit is_mem(fir_xifu_instr_t i);
      return (i == XFIRLW) || (i == XFIRSW);
   endfunction

   function automatic bit rdy(rec_t r);
      return !r.kl && r.cm && (!is_mem(r.instr) || r.md);
   endfunction

   initial begin : model
      bit   do_pop, nk;
      rec_t r;
      forever begin
         @(posedge clk);
         if (!rst_ni) begin
            q.delete();
            kill_pend = 0;
         end else begin
            do_pop = (q.size() > 0) && (q[0].kl || (rdy(q[0]) && result_ready_i));
            nk = 0;
            if (ex_valid_i && q.size() < DEPTH) begin
               r = '{id: ex_id_i, instr: ex_instr_i, rd: ex_rd_i, rs1: ex_rs1_i,
                     res: ex_result_i, rdata: '0, cm: 0, kl: 0, md: 0};
               q.push_back(r);
            end
            if (commit_valid_i)
               foreach (q[k])
                  if (q[k].id == commit_id_i) begin
                     if (commit_kill_i) begin q[k].kl = 1; nk = 1; end
                     else q[k].cm = 1;
                  end
            if (mem_result_valid_i)
               foreach (q[k])
                  if (q[k].id == mem_result_id_i && !q[k].kl) begin
                     q[k].md = 1;
                     q[k].rdata = mem_rdata_i;
                  end
            kill_pend    = nk;
            kill_pend_id = commit_id_i;
            if (do_pop) void'(q.pop_front());
         end
         chk_en = 1;
         @(negedge clk);
         if (chk_en) begin : cmp
            bit exp_rv, exp_rf;
            exp_rv = (q.size() > 0) && rdy(q[0]);
            exp_rf = exp_rv && result_ready_i && (q[0].instr == XFIRLW || q[0].instr == XFIRDOTP);
            check("m_ex_ready", 64'(ex_ready_o), 64'(q.size() < DEPTH));
            check("m_occupancy", 64'(occupancy_o), 64'(q.size()));
            check("m_kill", 64'(kill_o), 64'(kill_pend));
            if (kill_pend) check("m_kill_id", 64'(kill_id_o), 64'(kill_pend_id));
            check("m_result_valid", 64'(result_valid_o), 64'(exp_rv));
            if (exp_rv) begin
               check("m_result_id", 64'(result_id_o), 64'(q[0].id));
               check("m_result_data", 64'(result_data_o), 64'(q[0].res));
               check("m_result_rd", 64'(result_rd_o), is_mem(q[0].instr) ? 64'(q[0].rs1) : 64'(0));
               check("m_result_we", 64'(result_we_o), 64'(is_mem(q[0].instr)));
            end
            check("m_rf_write", 64'(rf_write_o), 64'(exp_rf));
            if (exp_rf) begin
               check("m_rf_addr", 64'(rf_addr_o), 64'(q[0].rd));
               check("m_rf_wdata", 64'(rf_wdata_o),
                     (q[0].instr == XFIRLW) ? 64'(q[0].rdata) : 64'(q[0].res));
            end
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic tick();
      @(posedge clk);
      #1;
      ex_valid_i = 0; commit_valid_i = 0; commit_kill_i = 0; mem_result_valid_i = 0;
   endtask

   task automatic push(input logic [3:0] id, input fir_xifu_instr_t ins, input logic [1:0] rd,
                       input logic [4:0] rs1, input logic [31:0] res);
      ex_valid_i = 1; ex_id_i = id; ex_instr_i = ins; ex_rd_i = rd; ex_rs1_i = rs1; ex_result_i = res;
   endtask

   task automatic commit(input logic [3:0] id, input logic kill);
      commit_valid_i = 1; commit_id_i = id; commit_kill_i = kill;
   endtask

   task automatic memres(input logic [3:0] id, input logic [31:0] d);
      mem_result_valid_i = 1; mem_result_id_i = id; mem_rdata_i = d;
   endtask

   initial begin
      rst_ni = 0; ex_valid_i = 0; ex_id_i = '0; ex_instr_i = XFIR_OTHER; ex_rd_i = '0;
      ex_rs1_i = '0; ex_result_i = '0; commit_valid_i = 0; commit_id_i = '0;
      commit_kill_i = 0; mem_result_valid_i = 0; mem_result_id_i = '0; mem_rdata_i = '0;
      result_ready_i = 0;
      tick();
      #2;
      check("rst_ex_ready", 64'(ex_ready_o), 64'(1));
      check("rst_occupancy", 64'(occupancy_o), 64'(0));
      check("rst_result_valid", 64'(result_valid_o), 64'(0));
      check("rst_kill", 64'(kill_o), 64'(0));
      tick();
      rst_ni = 1;

      // 1: DOTP, commit, result, rf write
      tick();
      push(4'd3, XFIRDOTP, 2'd1, 5'd0, 32'h10);
      tick();
      commit(4'd3, 0);
      tick();
      #2;
      check("t1_valid", 64'(result_valid_o), 64'(1));
      check("t1_id", 64'(result_id_o), 64'(3));
      check("t1_we", 64'(result_we_o), 64'(0));
      check("t1_data", 64'(result_data_o), 64'h10);
      result_ready_i = 1;
      #2;
      check("t1_rf_write", 64'(rf_write_o), 64'(1));
      check("t1_rf_addr", 64'(rf_addr_o), 64'(1));
      check("t1_rf_wdata", 64'(rf_wdata_o), 64'h10);
      tick();
      result_ready_i = 0;

      // 2: LW with memory result before commit
      push(4'd5, XFIRLW, 2'd2, 5'd10, 32'h1004);
      tick();
      memres(4'd5, 32'hCAFE);
      tick();
      #2;
      check("t2_wait_commit", 64'(result_valid_o), 64'(0));
      commit(4'd5, 0);
      tick();
      #2;
      check("t2_valid", 64'(result_valid_o), 64'(1));
      check("t2_rd", 64'(result_rd_o), 64'(10));
      check("t2_data", 64'(result_data_o), 64'h1004);
      check("t2_we", 64'(result_we_o), 64'(1));
      result_ready_i = 1;
      #2;
      check("t2_rf_wdata", 64'(rf_wdata_o), 64'hCAFE);
      check("t2_rf_addr", 64'(rf_addr_o), 64'(2));
      tick();
      result_ready_i = 0;

      // 3: fill, back-pressure, in-order drain; refused push while full
      for (int i = 0; i < 4; i++) begin
         push(4'(i), XFIRDOTP, 2'(i), 5'd0, 32'h100 + 32'(i));
         commit(4'(i), 0);
         tick();
      end
      #2;
      check("t3_full_ready", 64'(ex_ready_o), 64'(0));
      check("t3_full_occ", 64'(occupancy_o), 64'(4));
      check("t3_head0", 64'(result_id_o), 64'(0));
      result_ready_i = 1;
      push(4'd9, XFIR_OTHER, 2'd0, 5'd0, 32'h9);
      #2;
      check("t3_refused", 64'(ex_ready_o), 64'(0));
      tick();
      push(4'd9, XFIR_OTHER, 2'd0, 5'd0, 32'h9);
      #2;
      check("t3_ready_back", 64'(ex_ready_o), 64'(1));
      check("t3_occ_after_pop", 64'(occupancy_o), 64'(3));
      check("t3_head1", 64'(result_id_o), 64'(1));
      tick();
      #2;
      check("t3_occ_push_pop", 64'(occupancy_o), 64'(3));
      check("t3_head2", 64'(result_id_o), 64'(2));
      tick();
      #2;
      check("t3_head3", 64'(result_id_o), 64'(3));
      tick();
      #2;
      check("t3_id9_pending", 64'(result_valid_o), 64'(0));
      check("t3_occ1", 64'(occupancy_o), 64'(1));
      commit(4'd9, 0);
      tick();
      #2;
      check("t3_id9", 64'(result_id_o), 64'(9));
      check("t3_id9_no_rf", 64'(rf_write_o), 64'(0));
      tick();
      result_ready_i = 0;

      // 4: kill older, younger store completes
      push(4'd7, XFIRDOTP, 2'd0, 5'd0, 32'h77);
      tick();
      push(4'd8, XFIRSW, 2'd1, 5'd3, 32'h2008);
      tick();
      commit(4'd7, 1);
      tick();
      #2;
      check("t4_kill", 64'(kill_o), 64'(1));
      check("t4_kill_id", 64'(kill_id_o), 64'(7));
      check("t4_no_result", 64'(result_valid_o), 64'(0));
      commit(4'd8, 0);
      tick();
      #2;
      check("t4_kill_pulse", 64'(kill_o), 64'(0));
      check("t4_occ", 64'(occupancy_o), 64'(1));
      check("t4_wait_mem", 64'(result_valid_o), 64'(0));
      memres(4'd8, 32'h55);
      tick();
      #2;
      check("t4_id8", 64'(result_id_o), 64'(8));
      check("t4_rd", 64'(result_rd_o), 64'(3));
      check("t4_data", 64'(result_data_o), 64'h2008);
      result_ready_i = 1;
      #2;
      check("t4_sw_no_rf", 64'(rf_write_o), 64'(0));
      tick();
      result_ready_i = 0;

      // 5: younger committed first is held; mem result captured on push
      push(4'd1, XFIRDOTP, 2'd2, 5'd0, 32'h11);
      tick();
      push(4'd2, XFIRLW, 2'd3, 5'd7, 32'h22);
      memres(4'd2, 32'hBEEF);
      tick();
      commit(4'd2, 0);
      tick();
      #2;
      check("t5_blocked", 64'(result_valid_o), 64'(0));
      commit(4'd1, 0);
      tick();
      #2;
      check("t5_first", 64'(result_id_o), 64'(1));
      result_ready_i = 1;
      #2;
      check("t5_rf1", 64'(rf_wdata_o), 64'h11);
      tick();
      #2;
      check("t5_second", 64'(result_id_o), 64'(2));
      check("t5_rf2", 64'(rf_wdata_o), 64'hBEEF);
      check("t5_rf2_addr", 64'(rf_addr_o), 64'(3));
      tick();
      result_ready_i = 0;

      // 6: reset with pending entries flushes silently
      for (int i = 0; i < 3; i++) begin
         push(4'(10 + i), XFIRDOTP, 2'd0, 5'd0, 32'(i));
         tick();
      end
      commit(4'd10, 1);
      rst_ni = 0;
      tick();
      #2;
      check("t6_occ", 64'(occupancy_o), 64'(0));
      check("t6_ex_ready", 64'(ex_ready_o), 64'(1));
      check("t6_kill", 64'(kill_o), 64'(0));
      check("t6_valid", 64'(result_valid_o), 64'(0));
      check("t6_outs", 64'({result_id_o, result_data_o, result_rd_o, result_we_o,
                            rf_write_o, rf_addr_o, rf_wdata_o, kill_id_o}), 64'(0));
      rst_ni = 1;
      tick();
      #2;
      check("t6_no_kill_after", 64'(kill_o), 64'(0));
      push(4'd4, XFIRDOTP, 2'd1, 5'd0, 32'h44);
      commit(4'd4, 0);
      tick();
      #2;
      check("t6_after_reset", 64'(result_id_o), 64'(4));
      result_ready_i = 1;
      tick();
      result_ready_i = 0;
      tick();
      tick();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
